// File: rtl/wb_arbiter2_if.sv
// wshb_if: Wishbone bundle shared by the two-master arbiter and its slave.
//   adr_width : address width (data is fixed at 32 bits, sel at 4 bits)
//   modport master : drives the request fields and samples the response fields
//   modport slave  : samples the request fields and drives the response fields
interface wshb_if #(
  parameter int adr_width = 32
);
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [adr_width-1:0] adr;
  logic [3:0]           sel;
  logic [31:0]          dat_ms;
  logic [31:0]          dat_sm;
  logic                 ack;
  logic                 err;
  logic                 rty;
  logic [2:0]           cti;
  logic [1:0]           bte;

  modport master (
    output cyc, stb, we, adr, sel, dat_ms, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone arbiter in front of one shared slave.
// Master 0 is the display read path, master 1 the pattern/host write path.
// The slave is granted for a whole bus cycle (cyc high period); the grant is
// registered, while request/response routing is combinational once granted.
//
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   wb_s0  : master 0 port (wins the first tie after reset)
//   wb_s1  : master 1 port
//   wb_m   : port to the shared slave
//   grant  : one-hot grant, 01 = master 0, 10 = master 1, 00 = idle
//
// Build option:
//   WB_ARB_ROUND_ROBIN_EN : when defined, a tie in IDLE goes to the master not
//   served last. When undefined, master 0 always wins a tie (master 1 can
//   starve while master 0 keeps re-requesting).
module wb_arbiter2 #(
  parameter int adr_width = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  wshb_if.slave      wb_s0,
  wshb_if.slave      wb_s1,
  wshb_if.master     wb_m,
  output logic [1:0] grant
);

  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [adr_width-1:0] adr;
    logic [3:0]           sel;
    logic [31:0]          dat;
    logic [2:0]           cti;
    logic [1:0]           bte;
  } wb_req_t;

  typedef struct packed {
    logic ack;
    logic err;
    logic rty;
  } wb_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t  state_q, state_d;
  wb_req_t req [2];
  wb_req_t m_req;
  wb_rsp_t m_rsp;
  wb_rsp_t rsp [2];

  // Gather both master ports into request structs so the mux below is a loop.
  always_comb begin
    req[0].cyc = wb_s0.cyc;
    req[0].stb = wb_s0.stb;
    req[0].we  = wb_s0.we;
    req[0].adr = wb_s0.adr;
    req[0].sel = wb_s0.sel;
    req[0].dat = wb_s0.dat_ms;
    req[0].cti = wb_s0.cti;
    req[0].bte = wb_s0.bte;
    req[1].cyc = wb_s1.cyc;
    req[1].stb = wb_s1.stb;
    req[1].we  = wb_s1.we;
    req[1].adr = wb_s1.adr;
    req[1].sel = wb_s1.sel;
    req[1].dat = wb_s1.dat_ms;
    req[1].cti = wb_s1.cti;
    req[1].bte = wb_s1.bte;
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // last = index of the master that most recently finished a grant.
  // Resets to 1 so that master 0 takes the first tie.
  logic last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req[0].cyc && req[1].cyc) state_d = last_q ? GNT0 : GNT1;
        else if (req[0].cyc)          state_d = GNT0;
        else if (req[1].cyc)          state_d = GNT1;
      end
      GNT0: begin
        if (!req[0].cyc) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (!req[1].cyc) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fixed priority: master 0 wins every tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req[0].cyc)      state_d = GNT0;
        else if (req[1].cyc) state_d = GNT1;
      end
      GNT0:    if (!req[0].cyc) state_d = IDLE;
      GNT1:    if (!req[1].cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`endif

  // Grant is a pure decode of the registered state: no path from cyc.
  // The async reset clears the state, so the grant (and with it every routed
  // request and response) drops the moment rst_n falls.
  assign grant = {state_q == GNT1, state_q == GNT0};

  // Request mux: only the granted master reaches the slave, zeros when idle.
  always_comb begin
    m_req = '0;
    for (int i = 0; i < 2; i++)
      if (grant[i]) m_req = req[i];
  end

  assign wb_m.cyc    = m_req.cyc;
  assign wb_m.stb    = m_req.stb;
  assign wb_m.we     = m_req.we;
  assign wb_m.adr    = m_req.adr;
  assign wb_m.sel    = m_req.sel;
  assign wb_m.dat_ms = m_req.dat;
  assign wb_m.cti    = m_req.cti;
  assign wb_m.bte    = m_req.bte;

  // Responses go back to the granted master only; the other one stalls.
  assign m_rsp.ack = wb_m.ack;
  assign m_rsp.err = wb_m.err;
  assign m_rsp.rty = wb_m.rty;

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    assign rsp[i] = grant[i] ? m_rsp : '0;
  end

  assign wb_s0.ack = rsp[0].ack;
  assign wb_s0.err = rsp[0].err;
  assign wb_s0.rty = rsp[0].rty;
  assign wb_s1.ack = rsp[1].ack;
  assign wb_s1.err = rsp[1].err;
  assign wb_s1.rty = rsp[1].rty;

  // Read data is qualified by ack, so it can go to both masters untouched.
  assign wb_s0.dat_sm = wb_m.dat_sm;
  assign wb_s1.dat_sm = wb_m.dat_sm;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed bench for wb_arbiter2 with a small block-RAM
// style slave (registered ack, one ack every other cycle while stb is held).
// RAM word i resets to 32'hA500_0000 + i.
module tb_wb_arbiter2;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;

  wshb_if #(.adr_width(32)) s0_if ();
  wshb_if #(.adr_width(32)) s1_if ();
  wshb_if #(.adr_width(32)) m_if ();

  wb_arbiter2 #(.adr_width(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_s0 (s0_if),
    .wb_s1 (s1_if),
    .wb_m  (m_if),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // master-side drive
  logic        mcyc [2];
  logic        mstb [2];
  logic        mwe  [2];
  logic [31:0] madr [2];
  logic [31:0] mdat [2];

  assign s0_if.cyc = mcyc[0];  assign s1_if.cyc = mcyc[1];
  assign s0_if.stb = mstb[0];  assign s1_if.stb = mstb[1];
  assign s0_if.we  = mwe[0];   assign s1_if.we  = mwe[1];
  assign s0_if.adr = madr[0];  assign s1_if.adr = madr[1];
  assign s0_if.dat_ms = mdat[0]; assign s1_if.dat_ms = mdat[1];
  assign s0_if.sel = 4'hF;     assign s1_if.sel = 4'hF;
  assign s0_if.cti = 3'd0;     assign s1_if.cti = 3'd0;
  assign s0_if.bte = 2'd0;     assign s1_if.bte = 2'd0;

  logic [1:0] sack;
  assign sack = {s1_if.ack, s0_if.ack};

  // slave model
  logic [31:0] mem [64];
  logic        sl_ack;
  logic [31:0] sl_dat;
  logic        err_inj;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_ack <= 1'b0;
      sl_dat <= 32'd0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 + i;
    end else begin
      sl_ack <= m_if.cyc & m_if.stb & ~sl_ack;
      sl_dat <= mem[m_if.adr[7:2]];
      if (m_if.cyc && m_if.stb && m_if.we && !sl_ack) mem[m_if.adr[7:2]] <= m_if.dat_ms;
    end
  end

  assign m_if.ack    = sl_ack;
  assign m_if.dat_sm = sl_dat;
  assign m_if.err    = err_inj & m_if.cyc & m_if.stb;
  assign m_if.rty    = 1'b0;

  // grant log for the contention test
  logic       mon_en;
  logic [1:0] glog [$];
  always @(negedge clk) if (mon_en) glog.push_back(grant);

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int id, output logic ok, output logic [31:0] d);
    ok = 1'b0;
    d  = 32'd0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (sack[id]) begin
        ok = 1'b1;
        d  = (id == 0) ? s0_if.dat_sm : s1_if.dat_sm;
      end
    end
    if (!ok) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  // Request, take two acks, release cyc for exactly one cycle, repeat.
  task automatic auto_master(input int id, input int nb);
    logic        ok;
    logic [31:0] d;
    for (int b = 0; b < nb; b++) begin
      mcyc[id] = 1'b1; mstb[id] = 1'b1; mwe[id] = 1'b0; madr[id] = 32'h0;
      for (int a = 0; a < 2; a++) begin
        wait_ack(id, ok, d);
        step();
      end
      mcyc[id] = 1'b0; mstb[id] = 1'b0;
      step();
    end
  endtask

  logic [31:0] rd_exp [4];
  logic [1:0]  seq_exp [4];

  initial begin
    logic        ok;
    logic [31:0] d;
    logic [1:0]  seq [$];
    logic [1:0]  prev;
    int          zc;

    rd_exp = '{32'hA500_0004, 32'hA500_0005, 32'hA500_0006, 32'hA500_0007};
`ifdef WB_ARB_ROUND_ROBIN_EN
    seq_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    seq_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    mon_en = 1'b0;
    err_inj = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b1; mstb[i] = 1'b1; mwe[i] = 1'b0; madr[i] = 32'h0; mdat[i] = 32'h0;
    end

    // reset held with both masters requesting
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_mcyc", 32'(m_if.cyc), 32'h0);
      chk("rst_ack", 32'(sack), 32'h0);
    end
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rst_rel_grant", 32'(grant), 32'h1);
    step();
    mcyc[0] = 1'b0; mstb[0] = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
    step(); step(); step();

    // master 0 alone, 4-word read at 0x10..0x1C
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h10;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, ok, d);
      chk("rd_data", d, rd_exp[k]);
      chk("rd_grant", 32'(grant), 32'h1);
      chk("rd_s1_ack", 32'(s1_if.ack), 32'h0);
      step();
      if (k < 3) madr[0] = madr[0] + 32'h4;
      else begin mcyc[0] = 1'b0; mstb[0] = 1'b0; end
    end
    step(); step();

    // hold: master 1 writes while master 0 waits, then master 0 reads back
    mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1; madr[1] = 32'h40; mdat[1] = 32'hDEADBEEF;
    step();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0; madr[0] = 32'h40;
    wait_ack(1, ok, d);
    chk("hold_grant", 32'(grant), 32'h2);
    chk("hold_s0_ack", 32'(s0_if.ack), 32'h0);
    step();
    mcyc[1] = 1'b0; mstb[1] = 1'b0; mwe[1] = 1'b0;
    @(negedge clk);
    chk("hold_s0_ack2", 32'(s0_if.ack), 32'h0);
    wait_ack(0, ok, d);
    chk("hold_rd", d, 32'hDEADBEEF);
    chk("hold_grant0", 32'(grant), 32'h1);
    step();
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    step(); step();

    // error routing to granted master 1
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h0;
    step();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h0;
    err_inj = 1'b1;
    #1;
    chk("err_grant", 32'(grant), 32'h2);
    chk("err_s1", 32'(s1_if.err), 32'h1);
    chk("err_s0", 32'(s0_if.err), 32'h0);
    err_inj = 1'b0;
    step();
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    step(); step(); step();
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    step(); step();

    // contention, starting from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    glog.delete();
    mon_en = 1'b1;
`ifdef WB_ARB_ROUND_ROBIN_EN
    fork
      auto_master(0, 2);
      auto_master(1, 2);
    join
`else
    mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b0; madr[1] = 32'h0;
    auto_master(0, 4);
`endif
    mon_en = 1'b0;
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    prev = 2'b00;
    zc = 0;
    foreach (glog[i]) begin
      if (glog[i] != 2'b00) begin
        if (glog[i] != prev) begin
          if (seq.size() > 0) chk("arb_gap", 32'(zc), 32'd1);
          seq.push_back(glog[i]);
        end
        zc = 0;
      end else zc++;
      prev = glog[i];
    end
    chk("arb_runs", 32'(seq.size()), 32'd4);
    for (int k = 0; k < 4 && k < seq.size(); k++) chk("arb_seq", 32'(seq[k]), 32'(seq_exp[k]));
    step(); step(); step(); step();

    // reset in the middle of a master 0 burst
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h10;
    wait_ack(0, ok, d);
    chk("mid_mcyc_pre", 32'(m_if.cyc), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_mcyc", 32'(m_if.cyc), 32'h0);
    chk("mid_grant", 32'(grant), 32'h0);
    chk("mid_ack", 32'(sack), 32'h0);
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h0;
    step(); step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rel_grant", 32'(grant), 32'h2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
